pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline control and hazard unit for the 5-stage core: if_stage, id_stage, ex_stage, mem_stage and wb_stage separated by IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the PC register, the per-stage valid bits, and shadow control for each stage (rd, regwrite, memread, memwrite, rs1, rs2).
- Detects load-use and RAW hazards, resolves them by forwarding or by stall/bubble, and flushes on taken branches resolved in EX.
- Keeps saturating stall and flush performance counters.

Parameters:
- XLEN, 32, datapath/PC width
- REG_AW, 5, register index width
- FWD_EN, 1, 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling
- RESET_PC, 0, PC value after reset
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- id_rs1, id_rs2  in  REG_AW each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  instruction in ID actually reads that source
- id_rd  in  REG_AW  destination of the instruction in ID
- id_regwrite, id_memread, id_memwrite  in  1 each  decoded controls of the instruction in ID
- id_rs1_data, id_rs2_data  in  XLEN each  regfile read data
- ex_rs1_data, ex_rs2_data  in  XLEN each  operands held in the ID/EX register
- mem_result  in  XLEN  ALU result in the EX/MEM register
- wb_data  in  XLEN  writeback value
- ex_br_taken  in  1  branch in EX is taken
- ex_br_target  in  XLEN  branch target computed in EX
- pc  out  XLEN  fetch PC
- if_id_en  out  1  IF/ID register load enable
- stall, flush  out  1 each  hazard status for the current cycle
- id_valid, ex_valid, mem_valid, wb_valid  out  1 each  per-stage valid bits
- id_op_a, id_op_b  out  XLEN each  ID operands after WB bypass
- ex_op_a, ex_op_b  out  XLEN each  EX operands after forwarding
- fwd_a_sel, fwd_b_sel  out  2 each  forwarding source: 00 = register, 01 = WB, 10 = MEM
- mem_we  out  1  gated data-memory write enable
- wb_we  out  1  gated regfile write enable
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; all valid bits and shadow registers cleared.
  - Counters 0; all outputs driven from cleared state, so stall=flush=mem_we=wb_we=0.
  - Reset asserted mid-operation discards every in-flight instruction.
- flush = ex_valid & ex_br_taken.
- A source matches stage S when: valid_S & regwrite_S & rd_S!=0 & rd_S==rs (with the matching use_rs set). x0 never matches, is never forwarded and never stalls.
- stall = id_valid & !flush & hazard, where hazard is:
  - FWD_EN=1: an EX match on a load (ex_memread) — load-use.
  - FWD_EN=0: any match in EX, MEM or WB.
- Next-state priority, in order flush > stall > advance:
  - flush: pc<=ex_br_target; id_valid<=0; ex_valid<=0.
  - stall: pc and IF/ID held (if_id_en=0); ex_valid<=0 (bubble).
  - advance: pc<=pc+4 (mod 2^XLEN); id_valid<=1; EX shadow loads from the id_* controls; ex_valid<=id_valid.
- mem and wb shadows always advance: mem_*<=ex_*, wb_*<=mem_*.
- if_id_en = !stall | flush.
- Gated enables: mem_we = mem_valid & mem_memwrite; wb_we = wb_valid & wb_regwrite.
- Forwarding (combinational, FWD_EN=1):
  - EX operand: MEM match -> sel 10, mem_result; else WB match -> sel 01, wb_data; else sel 00, ex_rsX_data. MEM has priority over WB.
  - ID operand: WB match -> wb_data; else id_rsX_data.
  - FWD_EN=0: sel is always 00 and the ID/EX operands pass through unchanged.
- Counters: stall_cnt +1 on each stall cycle; flush_cnt +1 on each flush cycle. Both saturate at 2^CNT_W-1. A flush cycle never counts as a stall.
- Fetch latency: after reset release, the first instruction (at RESET_PC) is id_valid on the 2nd rising edge.

Test Plan:
- Reset: run 10 cycles, assert rst asynchronously mid-cycle -> pc=RESET_PC immediately; all valids, stall_cnt and flush_cnt = 0; no wb_we.
- EX forwarding: add x5,x1,x2 then add x6,x5,x3 back-to-back -> fwd_a_sel=10, ex_op_a=mem_result; stall never asserts.
- Load-use: lw x6 then add x7,x6,x6 -> exactly one stall cycle with pc held, one bubble (ex_valid=0); next cycle fwd_a_sel=fwd_b_sel=01; stall_cnt=1.
- Taken branch at pc 0x10 with ex_br_target 0x40 -> next pc=0x40; id_valid=ex_valid=0; flush_cnt=1. Same cycle with a load-use present -> no stall counted.
- x0 and WB bypass: writer rd=x0 followed by a dependent reader -> sel 00, no stall. Writer in WB while the reader is in ID -> id_op_a=wb_data.
- FWD_EN=0, dependency distance 1 -> 3 stall cycles, stall_cnt=3. With CNT_W=2, 5 stalls -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the pipeline datapath and the hazard/control unit.
// The datapath side (master) supplies decoded controls and operand data;
// the control unit (slave) returns PC, enables, valids and forwarded operands.
interface pipe_hazard_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // Datapath -> control unit
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   mem_result;
    logic [XLEN-1:0]   wb_data;
    logic              ex_br_taken;
    logic [XLEN-1:0]   ex_br_target;

    // Control unit -> datapath
    logic [XLEN-1:0]   pc;
    logic              if_id_en;
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    logic [XLEN-1:0]   id_op_a;
    logic [XLEN-1:0]   id_op_b;
    logic [XLEN-1:0]   ex_op_a;
    logic [XLEN-1:0]   ex_op_b;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              mem_we;
    logic              wb_we;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite,
               id_rs1_data, id_rs2_data, ex_rs1_data, ex_rs2_data,
               mem_result, wb_data, ex_br_taken, ex_br_target,
        input  pc, if_id_en, stall, flush,
               id_valid, ex_valid, mem_valid, wb_valid,
               id_op_a, id_op_b, ex_op_a, ex_op_b, fwd_a_sel, fwd_b_sel,
               mem_we, wb_we, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_regwrite, id_memread, id_memwrite,
               id_rs1_data, id_rs2_data, ex_rs1_data, ex_rs2_data,
               mem_result, wb_data, ex_br_taken, ex_br_target,
        output pc, if_id_en, stall, flush,
               id_valid, ex_valid, mem_valid, wb_valid,
               id_op_a, id_op_b, ex_op_a, ex_op_b, fwd_a_sel, fwd_b_sel,
               mem_we, wb_we, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control and hazard unit for a 5-stage in-order core.
// Holds the PC, per-stage valid bits and the control shadows needed to
// detect RAW/load-use hazards, selects forwarding sources, stalls/bubbles
// the front end, flushes on taken EX branches and counts stalls/flushes.
module pipe_hazard_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              REG_AW   = 5,
    parameter int              FWD_EN   = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    logic [XLEN-1:0]   pc_reg;
    logic              started;
    logic              id_v, ex_v, mem_v, wb_v;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic              ex_use_rs1, ex_use_rs2;
    logic              ex_regwrite, ex_memread, ex_memwrite;
    logic              mem_regwrite, mem_memwrite;
    logic              wb_regwrite;
    logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;

    logic              flush_c, hazard, stall_c;

    // A producer satisfies a source when it is live, writes a register,
    // targets that register and the register is not x0.
    function automatic logic src_match(input logic v, input logic rw,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs,
                                       input logic use_rs);
        return use_rs & v & rw & (rd != '0) & (rd == rs);
    endfunction

    // One slice per source operand (0 = rs1/op_a, 1 = rs2/op_b).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [REG_AW-1:0] id_src, ex_src;
            logic              id_use, ex_use;
            logic [XLEN-1:0]   id_rdata, ex_rdata;
            logic              hit_ex, hit_mem, hit_wb;
            logic [1:0]        sel;
            logic [XLEN-1:0]   ex_opnd, id_opnd;

            assign id_src   = (gi == 0) ? bus.id_rs1      : bus.id_rs2;
            assign id_use   = (gi == 0) ? bus.id_use_rs1  : bus.id_use_rs2;
            assign id_rdata = (gi == 0) ? bus.id_rs1_data : bus.id_rs2_data;
            assign ex_src   = (gi == 0) ? ex_rs1          : ex_rs2;
            assign ex_use   = (gi == 0) ? ex_use_rs1      : ex_use_rs2;
            assign ex_rdata = (gi == 0) ? bus.ex_rs1_data : bus.ex_rs2_data;

            // Dependencies of the instruction in ID on older in-flight writers.
            assign hit_ex  = src_match(ex_v,  ex_regwrite,  ex_rd,  id_src, id_use);
            assign hit_mem = src_match(mem_v, mem_regwrite, mem_rd, id_src, id_use);
            assign hit_wb  = src_match(wb_v,  wb_regwrite,  wb_rd,  id_src, id_use);

            // EX operand forwarding: the youngest producer (MEM) wins over WB.
            always_comb begin
                sel     = 2'b00;
                ex_opnd = ex_rdata;
                if (FWD_EN != 0) begin
                    if (src_match(mem_v, mem_regwrite, mem_rd, ex_src, ex_use)) begin
                        sel     = 2'b10;
                        ex_opnd = bus.mem_result;
                    end else if (src_match(wb_v, wb_regwrite, wb_rd, ex_src, ex_use)) begin
                        sel     = 2'b01;
                        ex_opnd = bus.wb_data;
                    end
                end
            end

            // ID operand bypass: covers the regfile write happening this same cycle.
            always_comb begin
                id_opnd = id_rdata;
                if ((FWD_EN != 0) && hit_wb) begin
                    id_opnd = bus.wb_data;
                end
            end
        end
    endgenerate

    // With forwarding only a load feeding its immediate successor must wait;
    // without it every outstanding writer of a source blocks ID.
    assign hazard = (FWD_EN != 0)
                  ? ((g_src[0].hit_ex | g_src[1].hit_ex) & ex_memread)
                  : (g_src[0].hit_ex | g_src[1].hit_ex | g_src[0].hit_mem |
                     g_src[1].hit_mem | g_src[0].hit_wb | g_src[1].hit_wb);
    assign flush_c = ex_v & bus.ex_br_taken;
    assign stall_c = id_v & ~flush_c & hazard;

    assign bus.pc        = pc_reg;
    assign bus.if_id_en  = ~stall_c | flush_c;
    assign bus.stall     = stall_c;
    assign bus.flush     = flush_c;
    assign bus.id_valid  = id_v;
    assign bus.ex_valid  = ex_v;
    assign bus.mem_valid = mem_v;
    assign bus.wb_valid  = wb_v;
    assign bus.ex_op_a   = g_src[0].ex_opnd;
    assign bus.ex_op_b   = g_src[1].ex_opnd;
    assign bus.fwd_a_sel = g_src[0].sel;
    assign bus.fwd_b_sel = g_src[1].sel;
    assign bus.id_op_a   = g_src[0].id_opnd;
    assign bus.id_op_b   = g_src[1].id_opnd;
    assign bus.mem_we    = mem_v & mem_memwrite;
    assign bus.wb_we     = wb_v & wb_regwrite;
    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;

    // PC, stage valids, control shadows and counters; flush > stall > advance.
    // The first edge after reset release only arms the front end so the fetch
    // at RESET_PC gets a full cycle; that instruction reaches ID on edge two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            started       <= 1'b0;
            id_v          <= 1'b0;
            ex_v          <= 1'b0;
            mem_v         <= 1'b0;
            wb_v          <= 1'b0;
            ex_rd         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_use_rs1    <= 1'b0;
            ex_use_rs2    <= 1'b0;
            ex_regwrite   <= 1'b0;
            ex_memread    <= 1'b0;
            ex_memwrite   <= 1'b0;
            mem_rd        <= '0;
            mem_regwrite  <= 1'b0;
            mem_memwrite  <= 1'b0;
            wb_rd         <= '0;
            wb_regwrite   <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            started      <= 1'b1;
            mem_v        <= ex_v;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memwrite <= ex_memwrite;
            wb_v         <= mem_v;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            if (started) begin
                if (flush_c) begin
                    pc_reg <= bus.ex_br_target;
                    id_v   <= 1'b0;
                    ex_v   <= 1'b0;
                end else if (stall_c) begin
                    ex_v   <= 1'b0;
                end else begin
                    pc_reg      <= pc_reg + XLEN'(4);
                    id_v        <= 1'b1;
                    ex_v        <= id_v;
                    ex_rd       <= bus.id_rd;
                    ex_rs1      <= bus.id_rs1;
                    ex_rs2      <= bus.id_rs2;
                    ex_use_rs1  <= bus.id_use_rs1;
                    ex_use_rs2  <= bus.id_use_rs2;
                    ex_regwrite <= bus.id_regwrite;
                    ex_memread  <= bus.id_memread;
                    ex_memwrite <= bus.id_memwrite;
                end
            end
            if (stall_c && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flush_c && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl. Two instances share the
// same stimulus: one with forwarding (16-bit counters), one stall-only with
// 2-bit saturating counters and a non-zero reset PC.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] PC0_F = 32'h0000_0000;
    localparam logic [31:0] PC0_S = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.XLEN(32), .REG_AW(5), .CNT_W(16)) bf ();
    pipe_hazard_ctrl_if #(.XLEN(32), .REG_AW(5), .CNT_W(2))  bs ();

    pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .FWD_EN(1), .RESET_PC(PC0_F), .CNT_W(16))
        dut_f (.clk(clk), .rst(rst), .bus(bf));
    pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .FWD_EN(0), .RESET_PC(PC0_S), .CNT_W(2))
        dut_s (.clk(clk), .rst(rst), .bus(bs));

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic        use1, use2, rw, mr, mw, br;
        logic [31:0] id_d1, id_d2, ex_d1, ex_d2, mem_res, wb_d, tgt;
    } in_t;

    // One in-flight instruction as seen by the reference model.
    typedef struct packed {
        logic       v;
        logic [4:0] rd, rs1, rs2;
        logic       use1, use2, rw, mr, mw;
    } ins_t;

    typedef struct {
        logic [31:0] pc;
        bit          armed;
        bit          idv;
        ins_t        ex, mem, wb;
        int          scnt, fcnt;
    } mdl_t;

    typedef struct {
        logic [31:0] pc;
        logic        if_id_en, stall, flush, idv, exv, memv, wbv, mem_we, wb_we;
        logic [31:0] ida, idb, exa, exb;
        logic [1:0]  sa, sb;
        int          scnt, fcnt;
    } obs_t;

    typedef struct {
        obs_t f;
        obs_t s;
    } pair_t;

    pair_t sbq[$];
    int    tests = 0;
    int    fails = 0;
    mdl_t  mf, ms;
    in_t   x;

    function automatic mdl_t model_reset(logic [31:0] pc0);
        mdl_t m;
        m.pc = pc0; m.armed = 0; m.idv = 0;
        m.ex = '0; m.mem = '0; m.wb = '0;
        m.scnt = 0; m.fcnt = 0;
        return m;
    endfunction

    function automatic bit hits(ins_t s, logic [4:0] rs, logic use_it);
        return use_it && s.v && s.rw && (rs != 5'd0) && (s.rd == rs);
    endfunction

    function automatic logic [1:0] ex_src(mdl_t m, logic [4:0] rs, logic use_it, bit fwd);
        if (!fwd) return 2'b00;
        if (hits(m.mem, rs, use_it)) return 2'b10;
        if (hits(m.wb, rs, use_it)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ex_val(logic [1:0] sel, logic [31:0] regv, in_t xi);
        return (sel == 2'b10) ? xi.mem_res : (sel == 2'b01) ? xi.wb_d : regv;
    endfunction

    function automatic obs_t predict(mdl_t m, in_t xi, bit fwd);
        obs_t e;
        bit ex_dep, old_dep, haz;
        e.flush = m.ex.v && xi.br;
        ex_dep  = hits(m.ex, xi.rs1, xi.use1) || hits(m.ex, xi.rs2, xi.use2);
        old_dep = hits(m.mem, xi.rs1, xi.use1) || hits(m.mem, xi.rs2, xi.use2) ||
                  hits(m.wb, xi.rs1, xi.use1) || hits(m.wb, xi.rs2, xi.use2);
        haz = fwd ? (ex_dep && m.ex.mr) : (ex_dep || old_dep);
        e.stall    = m.idv && !e.flush && haz;
        e.if_id_en = !e.stall || e.flush;
        e.pc   = m.pc;
        e.idv  = m.idv;
        e.exv  = m.ex.v;
        e.memv = m.mem.v;
        e.wbv  = m.wb.v;
        e.mem_we = m.mem.v && m.mem.mw;
        e.wb_we  = m.wb.v && m.wb.rw;
        e.sa  = ex_src(m, m.ex.rs1, m.ex.use1, fwd);
        e.sb  = ex_src(m, m.ex.rs2, m.ex.use2, fwd);
        e.exa = ex_val(e.sa, xi.ex_d1, xi);
        e.exb = ex_val(e.sb, xi.ex_d2, xi);
        e.ida = (fwd && hits(m.wb, xi.rs1, xi.use1)) ? xi.wb_d : xi.id_d1;
        e.idb = (fwd && hits(m.wb, xi.rs2, xi.use2)) ? xi.wb_d : xi.id_d2;
        e.scnt = m.scnt;
        e.fcnt = m.fcnt;
        return e;
    endfunction

    function automatic mdl_t step(mdl_t m, in_t xi, bit fwd, int cmax);
        obs_t e;
        mdl_t n;
        ins_t cur;
        e = predict(m, xi, fwd);
        n = m;
        cur = '{v: m.idv, rd: xi.rd, rs1: xi.rs1, rs2: xi.rs2, use1: xi.use1,
                use2: xi.use2, rw: xi.rw, mr: xi.mr, mw: xi.mw};
        if (e.stall && n.scnt < cmax) n.scnt++;
        if (e.flush && n.fcnt < cmax) n.fcnt++;
        n.wb  = m.mem;
        n.mem = m.ex;
        if (!m.armed) begin
            n.armed = 1;
        end else if (e.flush) begin
            n.pc = xi.tgt; n.idv = 0; n.ex.v = 0;
        end else if (e.stall) begin
            n.ex.v = 0;
        end else begin
            n.ex = cur; n.pc = m.pc + 32'd4; n.idv = 1;
        end
        return n;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, obs_t a, obs_t e);
        chk({tag, ".pc"},       64'(a.pc),       64'(e.pc));
        chk({tag, ".if_id_en"}, 64'(a.if_id_en), 64'(e.if_id_en));
        chk({tag, ".stall"},    64'(a.stall),    64'(e.stall));
        chk({tag, ".flush"},    64'(a.flush),    64'(e.flush));
        chk({tag, ".id_valid"}, 64'(a.idv),      64'(e.idv));
        chk({tag, ".ex_valid"}, 64'(a.exv),      64'(e.exv));
        chk({tag, ".mem_valid"},64'(a.memv),     64'(e.memv));
        chk({tag, ".wb_valid"}, 64'(a.wbv),      64'(e.wbv));
        chk({tag, ".mem_we"},   64'(a.mem_we),   64'(e.mem_we));
        chk({tag, ".wb_we"},    64'(a.wb_we),    64'(e.wb_we));
        chk({tag, ".id_op_a"},  64'(a.ida),      64'(e.ida));
        chk({tag, ".id_op_b"},  64'(a.idb),      64'(e.idb));
        chk({tag, ".ex_op_a"},  64'(a.exa),      64'(e.exa));
        chk({tag, ".ex_op_b"},  64'(a.exb),      64'(e.exb));
        chk({tag, ".fwd_a_sel"},64'(a.sa),       64'(e.sa));
        chk({tag, ".fwd_b_sel"},64'(a.sb),       64'(e.sb));
        chk({tag, ".stall_cnt"},64'(a.scnt),     64'(e.scnt));
        chk({tag, ".flush_cnt"},64'(a.fcnt),     64'(e.fcnt));
    endtask

    // Monitor: every cycle the DUTs present their outputs; pop and compare.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            pair_t p;
            obs_t  af, as;
            p = sbq.pop_front();
            af.pc = bf.pc; af.if_id_en = bf.if_id_en; af.stall = bf.stall; af.flush = bf.flush;
            af.idv = bf.id_valid; af.exv = bf.ex_valid; af.memv = bf.mem_valid; af.wbv = bf.wb_valid;
            af.mem_we = bf.mem_we; af.wb_we = bf.wb_we;
            af.ida = bf.id_op_a; af.idb = bf.id_op_b; af.exa = bf.ex_op_a; af.exb = bf.ex_op_b;
            af.sa = bf.fwd_a_sel; af.sb = bf.fwd_b_sel;
            af.scnt = int'(bf.stall_cnt); af.fcnt = int'(bf.flush_cnt);
            as.pc = bs.pc; as.if_id_en = bs.if_id_en; as.stall = bs.stall; as.flush = bs.flush;
            as.idv = bs.id_valid; as.exv = bs.ex_valid; as.memv = bs.mem_valid; as.wbv = bs.wb_valid;
            as.mem_we = bs.mem_we; as.wb_we = bs.wb_we;
            as.ida = bs.id_op_a; as.idb = bs.id_op_b; as.exa = bs.ex_op_a; as.exb = bs.ex_op_b;
            as.sa = bs.fwd_a_sel; as.sb = bs.fwd_b_sel;
            as.scnt = int'(bs.stall_cnt); as.fcnt = int'(bs.flush_cnt);
            cmp("fwd", af, p.f);
            cmp("stl", as, p.s);
            $display("[TB] cyc pc=%h stall=%0d/%0d flush=%0d/%0d sel=%0d%0d scnt=%0d/%0d",
                     bf.pc, bf.stall, bs.stall, bf.flush, bs.flush,
                     bf.fwd_a_sel, bf.fwd_b_sel, bf.stall_cnt, bs.stall_cnt);
        end
    end

    task automatic drive(in_t xi);
        bf.id_rs1 = xi.rs1; bf.id_rs2 = xi.rs2; bf.id_use_rs1 = xi.use1; bf.id_use_rs2 = xi.use2;
        bf.id_rd = xi.rd; bf.id_regwrite = xi.rw; bf.id_memread = xi.mr; bf.id_memwrite = xi.mw;
        bf.id_rs1_data = xi.id_d1; bf.id_rs2_data = xi.id_d2;
        bf.ex_rs1_data = xi.ex_d1; bf.ex_rs2_data = xi.ex_d2;
        bf.mem_result = xi.mem_res; bf.wb_data = xi.wb_d;
        bf.ex_br_taken = xi.br; bf.ex_br_target = xi.tgt;
        bs.id_rs1 = xi.rs1; bs.id_rs2 = xi.rs2; bs.id_use_rs1 = xi.use1; bs.id_use_rs2 = xi.use2;
        bs.id_rd = xi.rd; bs.id_regwrite = xi.rw; bs.id_memread = xi.mr; bs.id_memwrite = xi.mw;
        bs.id_rs1_data = xi.id_d1; bs.id_rs2_data = xi.id_d2;
        bs.ex_rs1_data = xi.ex_d1; bs.ex_rs2_data = xi.ex_d2;
        bs.mem_result = xi.mem_res; bs.wb_data = xi.wb_d;
        bs.ex_br_taken = xi.br; bs.ex_br_target = xi.tgt;
    endtask

    function automatic in_t rand_in();
        in_t r;
        r.rs1  = 5'($urandom_range(0, 3));
        r.rs2  = 5'($urandom_range(0, 3));
        r.rd   = 5'($urandom_range(0, 3));
        r.use1 = ($urandom_range(0, 7) != 0);
        r.use2 = ($urandom_range(0, 3) != 0);
        r.rw   = ($urandom_range(0, 3) != 0);
        r.mr   = r.rw && ($urandom_range(0, 2) == 0);
        r.mw   = !r.mr && ($urandom_range(0, 4) == 0);
        r.br   = ($urandom_range(0, 9) == 0);
        r.tgt  = $urandom & 32'hFFFF_FFFC;
        r.id_d1 = $urandom; r.id_d2 = $urandom;
        r.ex_d1 = $urandom; r.ex_d2 = $urandom;
        r.mem_res = $urandom; r.wb_d = $urandom;
        return r;
    endfunction

    // Asynchronous reset in the middle of a cycle: state must clear at once.
    task automatic mid_cycle_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst.pc_f",   64'(bf.pc), 64'(PC0_F));
        chk("rst.pc_s",   64'(bs.pc), 64'(PC0_S));
        chk("rst.valid_f",64'({bf.id_valid, bf.ex_valid, bf.mem_valid, bf.wb_valid}), 64'(0));
        chk("rst.valid_s",64'({bs.id_valid, bs.ex_valid, bs.mem_valid, bs.wb_valid}), 64'(0));
        chk("rst.cnt_f",  64'({bf.stall_cnt, bf.flush_cnt}), 64'(0));
        chk("rst.cnt_s",  64'({bs.stall_cnt, bs.flush_cnt}), 64'(0));
        chk("rst.we",     64'({bf.wb_we, bs.wb_we, bf.mem_we, bs.mem_we}), 64'(0));
        chk("rst.stall",  64'({bf.stall, bs.stall, bf.flush, bs.flush}), 64'(0));
        $display("[TB] async reset mid-cycle pc=%h/%h", bf.pc, bs.pc);
        @(posedge clk);
        #1 rst = 1'b0;
        mf = model_reset(PC0_F);
        ms = model_reset(PC0_S);
    endtask

    initial begin
        rst = 1'b1;
        x = '0;
        drive(x);
        mf = model_reset(PC0_F);
        ms = model_reset(PC0_S);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (c == 10 || c == 300) begin
                mid_cycle_reset();
            end
            x = rand_in();
            drive(x);
            sbq.push_back('{f: predict(mf, x, 1'b1), s: predict(ms, x, 1'b0)});
            @(posedge clk);
            #1;
            mf = step(mf, x, 1'b1, 65535);
            ms = step(ms, x, 1'b0, 3);
        end
        @(negedge clk);
        #1;
        chk("scoreboard.drained", 64'(sbq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
